// File: rtl/rf_check_pkg.sv
// +----------------------------------------------------------------------+
// | rf_check_pkg : shared types for the register-file check sequencer    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package rf_check_pkg;

   localparam int C_DWIDTH   = 32;
   localparam int C_NUM_REGS = 32;
   localparam int C_AWIDTH   = $clog2(C_NUM_REGS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      CHECK = 3'd2,
      PASS  = 3'd3,
      FAIL  = 3'd4,
      TOUT  = 3'd5
   } state_t;

   // Table entries are sized by the package widths; the sequencer's DWIDTH
   // and NUM_REGS must match C_DWIDTH and C_NUM_REGS.
   typedef struct packed {
      logic [C_DWIDTH-1:0] stage;
      logic [C_AWIDTH-1:0] regnum;
      logic [C_DWIDTH-1:0] expected;
   } entry_t;

   function automatic int cnt_width(input int timeout_cycles);
      return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rf_shadow.sv
// +----------------------------------------------------------------------+
// | rf_shadow : snooped shadow copy of the CPU register file, x0 reads 0 |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module rf_shadow
   import rf_check_pkg::*;
#(
   parameter int DWIDTH   = C_DWIDTH,
   parameter int NUM_REGS = C_NUM_REGS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wb_en,
   input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
   input  logic [DWIDTH-1:0]           wb_data,
   input  logic [$clog2(NUM_REGS)-1:0] rd_a_addr,
   output logic [DWIDTH-1:0]           rd_a_data,
   input  logic [$clog2(NUM_REGS)-1:0] rd_b_addr,
   output logic [DWIDTH-1:0]           rd_b_data
);

   logic [DWIDTH-1:0] r_regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   assign rd_a_data = (rd_a_addr == '0) ? '0 : r_regs[rd_a_addr];
   assign rd_b_data = (rd_b_addr == '0) ? '0 : r_regs[rd_b_addr];

endmodule

`default_nettype wire

// File: rtl/rf_check_sequencer.sv
// +----------------------------------------------------------------------+
// | rf_check_sequencer : walks a checkpoint table against a shadow RF    |
// | Option   : RF_CHECK_TRACE_EN adds checks_passed / stage_cycles       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rf_check_sequencer
   import rf_check_pkg::*;
#(
   parameter int DWIDTH         = C_DWIDTH,
   parameter int NUM_REGS       = C_NUM_REGS,
   parameter int DEPTH          = 16,
   parameter int FLAG_REG       = 20,
   parameter int TIMEOUT_CYCLES = 100
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wb_en,
   input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
   input  logic [DWIDTH-1:0]           wb_data,
   input  logic                        cfg_we,
   input  logic [$clog2(DEPTH)-1:0]    cfg_idx,
   input  logic [DWIDTH-1:0]           cfg_stage,
   input  logic [$clog2(NUM_REGS)-1:0] cfg_reg,
   input  logic [DWIDTH-1:0]           cfg_expected,
   input  logic [$clog2(DEPTH):0]      num_entries,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        fail,
   output logic                        timeout,
`ifdef RF_CHECK_TRACE_EN
   output logic [$clog2(DEPTH):0]      checks_passed,
   output logic [DWIDTH-1:0]           stage_cycles,
`endif
   output logic [$clog2(DEPTH)-1:0]    fail_idx,
   output logic [DWIDTH-1:0]           fail_got
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = cnt_width(TIMEOUT_CYCLES);

   state_t            r_state, w_state_nxt;
   logic [IW-1:0]     r_idx, w_idx_nxt, w_idx_inc;
   logic [IW:0]       r_num;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [IW-1:0]     r_fail_idx;
   logic [DWIDTH-1:0] r_fail_got;
   entry_t            r_table [DEPTH];
   entry_t            w_cur;
   logic [DWIDTH-1:0] w_nxt_stage, w_flag, w_chk;
   logic              w_busy, w_arm, w_fail_set, w_match, w_last, w_cnt_last;

   rf_shadow #(
      .DWIDTH   (DWIDTH),
      .NUM_REGS (NUM_REGS)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .rd_a_addr (AW'(FLAG_REG)),
      .rd_a_data (w_flag),
      .rd_b_addr (w_cur.regnum),
      .rd_b_data (w_chk)
   );

   assign w_busy      = (r_state == WAIT) || (r_state == CHECK);
   assign w_idx_inc   = r_idx + 1'b1;
   assign w_cur       = r_table[r_idx];
   assign w_nxt_stage = r_table[w_idx_inc].stage;
   assign w_match     = (w_chk == w_cur.expected);
   assign w_last      = ({1'b0, r_idx} == (r_num - 1'b1));
   assign w_cnt_last  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Table has no reset; it is only writable while no run is active.
   always_ff @(posedge clk) begin
      if (cfg_we && !w_busy) begin
         r_table[cfg_idx] <= '{stage: cfg_stage, regnum: cfg_reg, expected: cfg_expected};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_num      <= '0;
         r_fail_idx <= '0;
         r_fail_got <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_arm) begin
            r_num <= num_entries;
         end
         if (w_fail_set) begin
            r_fail_idx <= r_idx;
            r_fail_got <= w_chk;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_arm       = 1'b0;
      w_fail_set  = 1'b0;
      case (r_state)
         IDLE, PASS, FAIL, TOUT: begin
            if (start) begin
               w_arm       = 1'b1;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = (num_entries == '0) ? PASS : WAIT;
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_last) begin
               w_state_nxt = TOUT;
            end else if (w_flag == w_cur.stage) begin
               w_state_nxt = CHECK;
            end
         end
         CHECK: begin
            // Fail and final pass win over an expiring counter.
            w_cnt_nxt = r_cnt + 1'b1;
            if (!w_match) begin
               w_state_nxt = FAIL;
               w_fail_set  = 1'b1;
            end else if (w_last) begin
               w_state_nxt = PASS;
            end else if (w_cnt_last) begin
               w_state_nxt = TOUT;
            end else begin
               w_idx_nxt   = w_idx_inc;
               w_state_nxt = (w_nxt_stage == w_cur.stage) ? CHECK : WAIT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy     = w_busy;
   assign pass     = (r_state == PASS);
   assign fail     = (r_state == FAIL);
   assign timeout  = (r_state == TOUT);
   assign done     = pass | fail | timeout;
   assign fail_idx = r_fail_idx;
   assign fail_got = r_fail_got;

`ifdef RF_CHECK_TRACE_EN
   logic [IW:0]       r_checks_passed;
   logic [DWIDTH-1:0] r_stage_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_checks_passed <= '0;
         r_stage_cycles  <= '0;
      end else begin
         if (w_arm) begin
            r_checks_passed <= '0;
         end else if ((r_state == CHECK) && w_match) begin
            r_checks_passed <= r_checks_passed + 1'b1;
         end
         if ((r_state == WAIT) && (w_state_nxt == CHECK)) begin
            r_stage_cycles <= DWIDTH'(r_cnt);
         end
      end
   end

   assign checks_passed = r_checks_passed;
   assign stage_cycles  = r_stage_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_check_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_rf_check_sequencer : directed + random runs vs a timeline model   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rf_check_sequencer;

   localparam int DW    = 32;
   localparam int NR    = 32;
   localparam int DEPTH = 16;
   localparam int FLAG  = 20;
   localparam int T     = 100;
   localparam int WIN   = T + 4;

   logic        clk = 1'b0;
   logic        rst, wb_en, cfg_we, start;
   logic [4:0]  wb_addr, cfg_reg, num_entries;
   logic [31:0] wb_data, cfg_stage, cfg_expected;
   logic [3:0]  cfg_idx;
   logic        busy, done, pass, fail, timeout;
   logic [3:0]  fail_idx;
   logic [31:0] fail_got;
`ifdef RF_CHECK_TRACE_EN
   logic [4:0]  checks_passed;
   logic [31:0] stage_cycles;
`endif

   rf_check_sequencer #(
      .DWIDTH(DW), .NUM_REGS(NR), .DEPTH(DEPTH), .FLAG_REG(FLAG), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_stage(cfg_stage), .cfg_reg(cfg_reg),
      .cfg_expected(cfg_expected), .num_entries(num_entries), .start(start),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
`ifdef RF_CHECK_TRACE_EN
      .checks_passed(checks_passed), .stage_cycles(stage_cycles),
`endif
      .fail_idx(fail_idx), .fail_got(fail_got)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference state
   logic [31:0] m_shadow [NR];
   logic [31:0] t_stage [DEPTH];
   logic [31:0] t_exp   [DEPTH];
   logic [4:0]  t_reg   [DEPTH];
   logic [3:0]  m_fail_idx;
   logic [31:0] m_fail_got;
   int          m_checks_passed;
   logic [31:0] m_stage_cycles;

   // Per-run write schedule and shadow timeline (hist[c] = shadow after edge c)
   logic        s_en   [WIN];
   logic [4:0]  s_addr [WIN];
   logic [31:0] s_data [WIN];
   logic [31:0] hist   [WIN][NR];

   int          e_kind, e_done, e_idx, e_matched, e_arm;   // kind: 0 pass, 1 fail, 2 timeout
   logic [31:0] e_got;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      for (int r = 0; r < NR; r++) m_shadow[r] = '0;
      m_fail_idx      = '0;
      m_fail_got      = '0;
      m_checks_passed = 0;
      m_stage_cycles  = '0;
   endtask

   task automatic load(input int k, input logic [31:0] stg, input logic [4:0] rg, input logic [31:0] ex);
      cfg_we = 1'b1; cfg_idx = 4'(k); cfg_stage = stg; cfg_reg = rg; cfg_expected = ex;
      tick;
      cfg_we = 1'b0;
      t_stage[k] = stg; t_reg[k] = rg; t_exp[k] = ex;
   endtask

   task automatic clear_sched;
      for (int c = 0; c < WIN; c++) begin
         s_en[c] = 1'b0; s_addr[c] = '0; s_data[c] = '0;
      end
   endtask

   task automatic put(input int c, input int addr, input int data);
      s_en[c] = 1'b1; s_addr[c] = 5'(addr); s_data[c] = 32'(data);
   endtask

   // Walk the entries along the shadow timeline: each new stage waits for the
   // flag, then its checks run one per cycle; the budget ends at cycle T.
   task automatic predict(input int n);
      int t;
      t = 0; e_matched = 0; e_arm = -1; e_idx = 0; e_got = '0;
      if (n == 0) begin
         e_kind = 0; e_done = 0;
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (k == 0 || t_stage[k] != t_stage[k-1]) begin
            while (t < T - 1 && hist[t][FLAG] != t_stage[k]) t++;
            if (t >= T - 1) begin
               e_kind = 2; e_done = T;
               return;
            end
            e_arm = t;
            t++;
         end
         if (hist[t][t_reg[k]] != t_exp[k]) begin
            e_kind = 1; e_done = t + 1; e_idx = k; e_got = hist[t][t_reg[k]];
            return;
         end
         e_matched++;
         if (k == n - 1) begin
            e_kind = 0; e_done = t + 1;
            return;
         end
         if (t == T - 1) begin
            e_kind = 2; e_done = T;
            return;
         end
         t++;
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int c = 0; c < WIN; c++) begin
         for (int r = 0; r < NR; r++) hist[c][r] = (c == 0) ? m_shadow[r] : hist[c-1][r];
         if (s_en[c] && s_addr[c] != 0) hist[c][s_addr[c]] = s_data[c];
      end
      predict(n);
      for (int c = 0; c < WIN; c++) begin
         // Extra start / cfg pulses only land on edges where a run is active.
         start        = (c == 0) ? 1'b1 : (c <= e_done && $urandom_range(0, 3) == 0);
         num_entries  = (c == 0) ? 5'(n) : 5'($urandom_range(0, 16));
         wb_en        = s_en[c]; wb_addr = s_addr[c]; wb_data = s_data[c];
         cfg_we       = (c >= 1 && c <= e_done) ? 1'($urandom_range(0, 1)) : 1'b0;
         cfg_idx      = 4'($urandom_range(0, 15));
         cfg_stage    = 32'($urandom_range(0, 7));
         cfg_reg      = 5'($urandom_range(0, 31));
         cfg_expected = $urandom;
         tick;
         check({tag, "_busy"}, busy, c < e_done);
         check({tag, "_done"}, done, c >= e_done);
      end
      start = 1'b0; wb_en = 1'b0; cfg_we = 1'b0;
      if (e_kind == 1) begin
         m_fail_idx = 4'(e_idx);
         m_fail_got = e_got;
      end
      m_checks_passed = e_matched;
      if (e_arm >= 0) m_stage_cycles = 32'(e_arm);
      check({tag, "_pass"}, pass, e_kind == 0);
      check({tag, "_fail"}, fail, e_kind == 1);
      check({tag, "_timeout"}, timeout, e_kind == 2);
      check({tag, "_fail_idx"}, fail_idx, m_fail_idx);
      check({tag, "_fail_got"}, fail_got, m_fail_got);
`ifdef RF_CHECK_TRACE_EN
      check({tag, "_checks_passed"}, checks_passed, m_checks_passed);
      check({tag, "_stage_cycles"}, stage_cycles, m_stage_cycles);
`endif
      for (int r = 0; r < NR; r++) m_shadow[r] = hist[WIN-1][r];
   endtask

   initial begin
      rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; cfg_we = 1'b0; cfg_idx = '0;
      cfg_stage = '0; cfg_reg = '0; cfg_expected = '0; num_entries = '0; start = 1'b0;
      model_reset();
      tick; tick;
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_fail", fail, 0);
      check("rst_timeout", timeout, 0);
      check("rst_fail_idx", fail_idx, 0);
      check("rst_fail_got", fail_got, 0);
`ifdef RF_CHECK_TRACE_EN
      check("rst_checks_passed", checks_passed, 0);
      check("rst_stage_cycles", stage_cycles, 0);
`endif

      // Three-entry table, writes spaced so each stage is observed
      load(0, 1, 1, 300); load(1, 2, 1, 500); load(2, 2, 2, 100);
      clear_sched();
      put(1, 1, 100); put(4, 1, 300); put(7, FLAG, 1); put(10, 1, 500); put(13, 2, 100); put(16, FLAG, 2);
      run(3, "s1");
      check("s1_pass_const", pass, 1);
`ifdef RF_CHECK_TRACE_EN
      check("s1_checks_const", checks_passed, 3);
`endif

      clear_sched();
      put(1, 1, 100); put(4, 1, 300); put(7, FLAG, 1); put(10, 1, 500); put(13, 2, 99); put(16, FLAG, 2);
      run(3, "s2");
      check("s2_fail_const", fail, 1);
      check("s2_idx_const", fail_idx, 2);
      check("s2_got_const", fail_got, 99);

      clear_sched();
      put(1, 1, 100); put(4, 1, 300); put(7, FLAG, 1);
      run(3, "s3");
      check("s3_timeout_const", timeout, 1);
      check("s3_idx_const", fail_idx, 2);

      load(0, 1, 0, 0);
      clear_sched();
      put(1, FLAG, 0); put(3, 0, 1); put(5, 0, 5); put(9, FLAG, 1);
      run(1, "s4");
      check("s4_pass_const", pass, 1);

      // Reset in the middle of a wait
      load(0, 5, 1, 7);
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
      tick;
      wb_en = 1'b0;
      start = 1'b1; num_entries = 5'd1;
      tick;
      start = 1'b0;
      check("rw_busy_pre", busy, 1);
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_reset();
      check("rw_busy", busy, 0);
      check("rw_done", done, 0);
      check("rw_fail_got", fail_got, 0);
      load(0, 1, 1, 0);
      clear_sched();
      put(2, FLAG, 1);
      run(1, "rw");
      check("rw_pass_const", pass, 1);

      for (int it = 0; it < 40; it++) begin
         int n, cur;
         n   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
         cur = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) begin
            if (k > 0 && $urandom_range(0, 1) == 1) cur++;
            load(k, 32'(cur), 5'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
         end
         clear_sched();
         for (int c = 0; c < WIN; c++) begin
            if ($urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 4))
                  0:       put(c, 0, $urandom_range(0, 3));
                  4:       put(c, FLAG, $urandom_range(0, cur + 1));
                  default: put(c, $urandom_range(1, 3), $urandom_range(0, 3));
               endcase
            end
         end
         run(n, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
